// File: rtl/uncache_handler.sv
// Uncached access serialiser: arbitrates write-buffer stores and read-buffer loads
// onto the single uncached memory port, one transaction at a time.
module uncache_handler #(
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_w,
  input  logic [31:0] wb_waddr,
  input  logic [1:0]  wb_size,
  input  logic [31:0] wb_data,
  output logic        wb_ready,
  input  logic        rb_rvalid,
  input  logic [31:0] rb_raddr,
  input  logic [1:0]  rb_rsize,
  output logic        rb_uready,
  output logic        rb_uvalid,
  output logic [31:0] rb_udata,
  input  logic        rb_rready,
  output logic        mem_uvalid,
  output logic        mem_uwen,
  output logic [31:0] mem_uaddr,
  output logic [31:0] mem_udata,
  output logic [3:0]  mem_ustrobe,
  output logic [2:0]  mem_usize,
  input  logic        mem_mready,
  input  logic        mem_mvalid,
  input  logic [31:0] mem_mdata,
  output logic        mem_uready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WREQ  = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RREQ  = 3'd3;
  localparam logic [2:0] S_RRESP = 3'd4;
  localparam logic [2:0] S_RDONE = 3'd5;

  logic [2:0]  state_q,  state_d;
  logic        first_q,  first_d;
  logic [31:0] addr_q,   addr_d;
  logic [1:0]  size_q,   size_d;
  logic [2:0]  usize_q,  usize_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [31:0] rdata_q,  rdata_d;

  // Size encoding: 1 byte, 2 half, 3 word; 0 (nil) behaves as word.
  function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd1:    return 4'b0001 << lane;
      2'd2:    return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] usize_of(input logic [1:0] size);
    case (size)
      2'd1:    return 3'd0;
      2'd2:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [31:0] read_mask(input logic [1:0] size);
    case (size)
      2'd1:    return 32'h0000_00FF;
      2'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    first_d  = 1'b0;
    addr_d   = addr_q;
    size_d   = size_q;
    usize_d  = usize_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (wb_w && (WRITE_FIRST || !rb_rvalid)) begin
          state_d  = S_WREQ;
          first_d  = 1'b1;
          addr_d   = wb_waddr;
          size_d   = wb_size;
          usize_d  = usize_of(wb_size);
          wdata_d  = wb_data << {wb_waddr[1:0], 3'b000};
          strobe_d = strobe_of(wb_size, wb_waddr[1:0]);
        end else if (rb_rvalid) begin
          state_d  = S_RREQ;
          first_d  = 1'b1;
          addr_d   = rb_raddr;
          size_d   = rb_rsize;
          usize_d  = usize_of(rb_rsize);
          wdata_d  = '0;
          strobe_d = '0;
        end
      end
      S_WREQ:  if (mem_mready) state_d = S_WRESP;
      S_WRESP: if (mem_mvalid) state_d = S_IDLE;
      S_RREQ:  if (mem_mready) state_d = S_RRESP;
      S_RRESP: begin
        if (mem_mvalid) begin
          rdata_d = (mem_mdata >> {addr_q[1:0], 3'b000}) & read_mask(size_q);
          state_d = S_RDONE;
        end
      end
      S_RDONE: if (rb_rready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      usize_q  <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      usize_q  <= usize_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
    end
  end

  // Capture pulses fire only on the first cycle after leaving IDLE.
  assign wb_ready    = first_q && (state_q == S_WREQ);
  assign rb_uready   = first_q && (state_q == S_RREQ);
  assign mem_uvalid  = (state_q == S_WREQ) || (state_q == S_RREQ);
  assign mem_uwen    = (state_q == S_WREQ);
  assign mem_uready  = (state_q == S_WRESP) || (state_q == S_RRESP);
  assign mem_uaddr   = addr_q;
  assign mem_udata   = wdata_q;
  assign mem_ustrobe = strobe_q;
  assign mem_usize   = usize_q;
  assign rb_uvalid   = (state_q == S_RDONE);
  assign rb_udata    = rdata_q;

endmodule
